top_zero_tie: RTL and testbench
===============================

// Module: top_zero_tie
//
// PURPOSE
// - Constant logic-low source: drives a single output permanently to 1'b0.
// - Ties off an unused or disabled signal at the top level, so downstream logic
//   always sees a defined, known-low level.
// - Clock and reset ports exist only to match the standard block interface.
//   They have no functional effect on the output.
//
// PARAMETERS
// - None. Output width and value are fixed: 1 bit, value 1'b0.
//
// PORTS
// clk    input   1  system clock; no effect on out
// rst_n  input   1  asynchronous, active-low reset; no effect on out
// out    output  1  constant logic 0
//
// BEHAVIOUR
// - Interface: one clock (clk). Reset (rst_n) is asynchronous and active-low.
// - out is a continuous combinational tie to 1'b0. It never passes through a flop.
// - Timing:
//   - out is 0 from simulation time 0, before any clock edge and before any reset.
//   - Latency is zero. There is no pipeline and no state.
// - Reset:
//   - Reset value of out is 0.
//   - Asserting, holding or releasing rst_n does not change out.
//   - No glitch on any reset edge, including reset applied mid-operation.
// - Clock:
//   - out holds 0 on every posedge and negedge of clk.
//   - out stays 0 while clk is stopped, gated or toggling at any rate.
// - Unknown inputs: out is strictly 0 and never X or Z, even when clk or rst_n is
//   X or Z.
// - Forbidden:
//   - No internal state, counters, handshakes or state machine.
//   - No tristate drivers.
//   - Nothing that can make out differ from 0 under any input combination.
// - Synthesis: reduces to a tie-low cell. The unused clk and rst_n inputs must not
//   be optimised into any path that drives out.
//
// TESTING
// 1. Time 0: sample out before the first clk edge -> out === 1'b0 (not X).
// 2. Free-running clk, 10 time-unit period, rst_n=1:
//    - sample on both edges for 100 samples;
//    - expect out === 1'b0 every sample, 0 mismatches.
// 3. Asynchronous reset mid-run:
//    - drop rst_n to 0 between clk edges, hold for 3 cycles, then release;
//    - expect out === 1'b0 throughout, with no transition.
// 4. Stopped clock: hold clk at 0 for 50 time units with rst_n toggling -> out === 1'b0.
// 5. Unknown inputs: drive clk=1'bx and rst_n=1'bz -> out === 1'b0.
// 6. Compare against a golden 1'b0 using case-equality (===), so X or Z on out
//    counts as a mismatch. Pass criterion: 0 mismatches over the whole run.

Source files
------------

// File: rtl/top_zero_tie.sv
// rtl/top_zero_tie.sv - constant logic-low source with a standard clk/rst_n block interface
// out is a pure combinational tie to 0; clk and rst_n are never routed toward it.
module top_zero_tie (
  input  logic clk,
  input  logic rst_n,
  output logic out
);

  assign out = 1'b0;

  // Interface-only inputs are reduced into a sink net that drives nothing.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, rst_n};

endmodule

// File: tb/tb_top_zero_tie.sv
// tb/tb_top_zero_tie.sv - directed self-checking bench for top_zero_tie
module tb_top_zero_tie;

  logic clk;
  logic rst_n;
  logic out;
  logic clk_en;
  logic watch_en;

  int n_checks;
  int n_fail;

  top_zero_tie u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (out)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %b, expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Any movement of out during the reset window is a glitch.
  always @(out) if (watch_en) check_bit("out_transition", out, 1'b0);

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rst_n    = 1'b1;
    clk_en   = 1'b0;
    watch_en = 1'b0;

    #1;
    check_bit("time0_before_clk", out, 1'b0);

    clk_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check_bit("run_posedge", out, 1'b0);
      @(negedge clk); #1;
      check_bit("run_negedge", out, 1'b0);
    end

    watch_en = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_bit("rst_assert", out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_bit("rst_hold", out, 1'b0);
    end
    #2;
    rst_n = 1'b1;
    #1;
    check_bit("rst_release", out, 1'b0);
    @(posedge clk); #1;
    check_bit("post_rst_posedge", out, 1'b0);
    watch_en = 1'b0;

    clk_en = 1'b0;
    clk    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #5;
      rst_n = ~rst_n;
      #5;
      check_bit("clk_stopped_rst_toggle", out, 1'b0);
    end
    rst_n = 1'b1;

    clk   = 1'bx;
    rst_n = 1'bz;
    #3;
    check_bit("clk_x_rst_z", out, 1'b0);
    clk   = 1'bz;
    rst_n = 1'bx;
    #3;
    check_bit("clk_z_rst_x", out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
